// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full-adder cell: s = odd parity, co = majority of the three inputs.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, one result bit per clock, LSB first.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_co, w_accept, w_last;

  fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtraction reuses the adder: a + ~b + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
`else
      r_b     <= b;
      r_carry <= 1'b0;
`endif
    end else if (r_state == ADD) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition, sampled on clk.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on an accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL have port sum  output  WIDTH  result bits, LSB-first assembled.
REQ-010 SHALL have port cout  output  1  final carry out of the MSB.

Function
REQ-011 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-012 SHALL accept start only in IDLE: load a and b into shift registers, clear carry to 0, clear bit counter, and go to ADD.
REQ-013 SHALL process one bit per ADD cycle: full-adder cell on (a_sr[0], b_sr[0], carry); result bit shifted into sum register from the MSB side; carry register updated with the majority output; operand registers shifted right.
REQ-014 SHALL leave ADD after exactly WIDTH cycles (counter reaches WIDTH-1) and enter DONE.
REQ-015 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-016 SHALL give latency: start sampled high at edge T -> done high during cycle T+WIDTH+1.
REQ-017 SHALL assert busy in ADD and DONE, and deassert it in IDLE.
REQ-018 SHALL hold sum and cout stable from DONE until the next accepted start.
REQ-019 SHALL produce sum equal to (a+b) mod 2^WIDTH and cout equal to bit WIDTH of a+b.
REQ-020 SHALL ignore start while busy; in-flight operands are not disturbed.
REQ-021 SHALL ignore a start that is high during DONE; a start held high into the following IDLE cycle is accepted there.
REQ-022 SHALL ignore changes on a and b after capture.
REQ-023 SHALL size the bit counter at clog2(WIDTH) bits with no wrap beyond WIDTH-1.

Reset
REQ-024 SHALL, on rst high at a clk edge, force state IDLE, and clear busy, done, sum, cout, the carry register, the counter and the shift registers to 0.
REQ-025 SHALL abort any operation in progress when rst is applied mid-operation, with no done pulse, and SHALL accept start on the first cycle after rst deasserts.
REQ-026 SHALL give rst priority over start when both are high.

Configuration
REQ-027 SHALL, with SERIAL_ADDER_SUB_EN defined, add input port sub (1 bit, captured with start): when sub=1, b is inverted at load and carry initialises to 1, so sum = (a-b) mod 2^WIDTH and cout = 1 when no borrow.
REQ-028 SHALL, without SERIAL_ADDER_SUB_EN, have no sub port and perform addition only.

Structure
REQ-029 SHALL define the FSM state encoding (IDLE=2'd0, ADD=2'd1, DONE=2'd2) in shared package serial_adder_pkg.
REQ-030 SHALL instantiate one combinational sub-module fa_cell (inputs x, y, ci; outputs s = odd parity, co = majority) as the per-bit datapath.

Verification
REQ-031 SHALL cover: WIDTH=8, a=0x3C, b=0x5A, start at T -> done at T+9, sum=0x96, cout=0.
REQ-032 SHALL cover: a=0xFF, b=0x01 -> sum=0x00, cout=1; busy high from T+1 through T+9.
REQ-033 SHALL cover: start pulsed again at T+4 with a=0x11, b=0x22 -> ignored; result remains that of the first operation.
REQ-034 SHALL cover: rst asserted at T+5 of an operation -> busy=0, done never pulses; a new start with a=0x01, b=0x02 -> sum=0x03.
REQ-035 SHALL cover: start held high continuously -> operations accepted every WIDTH+2 cycles, each with one done pulse.
REQ-036 SHALL cover, with SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
